// File: rtl/decode_pkg.sv
// Shared widths, file selectors and payload types for the decode-stage register bank.
package decode_pkg;

  localparam int XLEN  = 32;
  localparam int NREG  = 32;
  localparam int NFILE = 2;
  localparam int NRD   = 3;
  localparam int TAGW  = 64;
  localparam int AW    = $clog2(NREG);
  localparam int FW    = (NFILE > 1) ? $clog2(NFILE) : 1;

  typedef enum logic [FW-1:0] {
    FILE_INT = FW'(0),
    FILE_FP  = FW'(1)
  } file_e;

  typedef logic [AW-1:0] reg_addr_t;
  typedef logic [FW-1:0] file_sel_t;

  typedef struct packed {
    reg_addr_t       rd_addr;
    file_sel_t       rd_file;
    logic            rd_we;
    logic [TAGW-1:0] tag;
  } dst_payload_t;

  // Flat position of (file, reg) in the busy/storage arrays; -1 when out of range.
  function automatic int flat_index(input int file, input int addr,
                                    input int nfile, input int nreg);
    if (file < nfile && addr < nreg) return file * nreg + addr;
    return -1;
  endfunction

endpackage

// File: rtl/regbank_scoreboard.sv
// Per-register busy bits with issue-set / writeback-clear / flush-clear priority,
// plus a registered popcount of the busy bits.
module regbank_scoreboard #(
  parameter int NREG   = 32,
  parameter int NFILE  = 2,
  parameter int ADDR_W = 5,
  parameter int FILE_W = 1,
  localparam int NB    = NFILE * NREG,
  localparam int CNT_W = $clog2(NB) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en,
  input  logic [FILE_W-1:0] set_file,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              wb_en,
  input  logic [FILE_W-1:0] wb_file,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic              kill_en,
  input  logic [FILE_W-1:0] kill_file,
  input  logic [ADDR_W-1:0] kill_addr,
  output logic [NB-1:0]     busy,
  output logic [CNT_W-1:0]  pending_cnt
);
  import decode_pkg::*;

  logic [NB-1:0]    busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NB-1:0]    set_oh, clr_oh;

  function automatic logic [NB-1:0] onehot(input logic [FILE_W-1:0] f,
                                           input logic [ADDR_W-1:0] a);
    int k;
    k = flat_index(int'(f), int'(a), NFILE, NREG);
    onehot = '0;
    for (int j = 0; j < NB; j++) begin
      if (k == j) onehot[j] = 1'b1;
    end
  endfunction

  always_comb begin
    set_oh    = set_en ? onehot(set_file, set_addr) : '0;
    // The hardwired zero register (flat index 0) can never become busy.
    set_oh[0] = 1'b0;
    clr_oh    = (wb_en ? onehot(wb_file, wb_addr) : '0)
              | (kill_en ? onehot(kill_file, kill_addr) : '0);
    // Set is applied after the clears so a same-edge issue keeps the bit.
    busy_d    = (busy_q & ~clr_oh) | set_oh;
    cnt_d     = '0;
    for (int j = 0; j < NB; j++) begin
      cnt_d = cnt_d + CNT_W'(busy_d[j]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy        = busy_q;
  assign pending_cnt = cnt_q;

endmodule

// File: rtl/decode_regbank.sv
// Decode-stage register bank: NFILE register files, NRD read ports with WB bypass,
// scoreboard-gated issue into a one-entry valid/ready output register with flush.
module decode_regbank #(
  parameter int XLEN   = decode_pkg::XLEN,
  parameter int NREG   = decode_pkg::NREG,
  parameter int NFILE  = decode_pkg::NFILE,
  parameter int NRD    = decode_pkg::NRD,
  parameter int TAGW   = decode_pkg::TAGW,
  localparam int ADDR_W = $clog2(NREG),
  localparam int FILE_W = (NFILE > 1) ? $clog2(NFILE) : 1,
  localparam int NB     = NFILE * NREG,
  localparam int CNT_W  = $clog2(NB) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NRD*ADDR_W-1:0]    in_rs_addr,
  input  logic [NRD*FILE_W-1:0]    in_rs_file,
  input  logic [NRD-1:0]           in_rs_used,
  input  logic [ADDR_W-1:0]        in_rd_addr,
  input  logic [FILE_W-1:0]        in_rd_file,
  input  logic                     in_rd_we,
  input  logic [TAGW-1:0]          in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NRD*XLEN-1:0]      out_rs_data,
  output logic [ADDR_W-1:0]        out_rd_addr,
  output logic [FILE_W-1:0]        out_rd_file,
  output logic                     out_rd_we,
  output logic [TAGW-1:0]          out_tag,
  input  logic                     wb_en,
  input  logic [FILE_W-1:0]        wb_file,
  input  logic [ADDR_W-1:0]        wb_addr,
  input  logic [XLEN-1:0]          wb_data,
  input  logic                     flush,
  output logic [CNT_W-1:0]         pending_cnt
);
  import decode_pkg::*;

  // Handshake: a transfer on either side happens on a clk edge where valid and
  // ready are both high; ready never depends on the same side's valid, and an
  // offered entry may be withdrawn or changed freely while ready is low.

  typedef struct packed {
    logic [ADDR_W-1:0] rd_addr;
    logic [FILE_W-1:0] rd_file;
    logic              rd_we;
    logic [TAGW-1:0]   tag;
  } payload_t;

  logic [XLEN-1:0]     mem_q [NB];
  logic                out_valid_q, out_valid_d;
  payload_t            payload_q, payload_d;
  logic [NRD*XLEN-1:0] rs_data_q, rs_data_d;

  logic [NB-1:0]       busy;
  logic [NB-1:0]       wb_oh, wb_we, rd_oh, src_oh;
  logic [XLEN-1:0]     src_val;
  logic [NRD*XLEN-1:0] rs_fetch;
  logic                src_haz, dst_haz, accept, kill_en, set_en;

  function automatic logic [NB-1:0] onehot(input logic [FILE_W-1:0] f,
                                           input logic [ADDR_W-1:0] a);
    int k;
    k = flat_index(int'(f), int'(a), NFILE, NREG);
    onehot = '0;
    for (int j = 0; j < NB; j++) begin
      if (k == j) onehot[j] = 1'b1;
    end
  endfunction

  always_comb begin
    wb_oh    = wb_en ? onehot(wb_file, wb_addr) : '0;
    wb_we    = wb_oh;
    wb_we[0] = 1'b0;
    rd_oh    = onehot(in_rd_file, in_rd_addr);
    src_oh   = '0;
    src_val  = '0;
    src_haz  = 1'b0;
    rs_fetch = '0;
    for (int i = 0; i < NRD; i++) begin
      src_oh  = onehot(in_rs_file[i*FILE_W +: FILE_W], in_rs_addr[i*ADDR_W +: ADDR_W]);
      src_val = '0;
      for (int j = 0; j < NB; j++) begin
        if (src_oh[j]) src_val = mem_q[j];
      end
      // Write-first: a same-cycle writeback beats the stored copy; x0 beats both.
      if (|(src_oh & wb_we)) src_val = wb_data;
      if (!in_rs_used[i] || src_oh[0]) src_val = '0;
      rs_fetch[i*XLEN +: XLEN] = src_val;
      src_haz = src_haz | (in_rs_used[i] & (|(src_oh & busy & ~wb_oh)));
    end
    dst_haz  = in_rd_we & (|(rd_oh & busy & ~wb_oh));
  end

  assign in_ready = (!out_valid_q || out_ready) && !src_haz && !dst_haz && !flush;
  assign accept   = in_valid && in_ready;
  assign set_en   = accept && in_rd_we;
  assign kill_en  = flush && out_valid_q && payload_q.rd_we;

  always_comb begin
    out_valid_d = out_valid_q;
    payload_d   = payload_q;
    rs_data_d   = rs_data_q;
    if (flush || out_ready) out_valid_d = 1'b0;
    if (accept) begin
      out_valid_d       = 1'b1;
      payload_d.rd_addr = in_rd_addr;
      payload_d.rd_file = in_rd_file;
      payload_d.rd_we   = in_rd_we;
      payload_d.tag     = in_tag;
      rs_data_d         = rs_fetch;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      payload_q   <= '0;
      rs_data_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      payload_q   <= payload_d;
      rs_data_q   <= rs_data_d;
    end
  end

  // Architectural storage is deliberately left without reset.
  always_ff @(posedge clk) begin
    for (int j = 0; j < NB; j++) begin
      if (wb_we[j]) mem_q[j] <= wb_data;
    end
  end

  regbank_scoreboard #(
    .NREG   (NREG),
    .NFILE  (NFILE),
    .ADDR_W (ADDR_W),
    .FILE_W (FILE_W)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .set_en      (set_en),
    .set_file    (in_rd_file),
    .set_addr    (in_rd_addr),
    .wb_en       (wb_en),
    .wb_file     (wb_file),
    .wb_addr     (wb_addr),
    .kill_en     (kill_en),
    .kill_file   (payload_q.rd_file),
    .kill_addr   (payload_q.rd_addr),
    .busy        (busy),
    .pending_cnt (pending_cnt)
  );

  assign out_valid   = out_valid_q;
  assign out_rs_data = rs_data_q;
  assign out_rd_addr = payload_q.rd_addr;
  assign out_rd_file = payload_q.rd_file;
  assign out_rd_we   = payload_q.rd_we;
  assign out_tag     = payload_q.tag;

endmodule
